// File: rtl/core_mem_pkg.sv
// Shared definitions for the core memory port: response ownership and bus widths.
package core_mem_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 12;
    localparam int unsigned DATA_W         = 32;
    localparam int unsigned BE_W           = DATA_W / 8;
    localparam int unsigned STARVE_W       = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } resp_owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, load/store and memory-side signals of the shared single-port memory.
interface mem_port_arbiter_if
    import core_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT
);

    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [BE_W-1:0]   d_be;
    logic [31:0]       d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic [BE_W-1:0]   mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Requesters and memory model side.
    modport master (
        output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

    // Arbiter side.
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store onto one synchronous-read memory port; data has
// priority, a starvation counter guarantees fetch progress, responses are steered back.
module mem_port_arbiter
    import core_mem_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEFAULT,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus
);

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    resp_owner_e         owner_q, owner_d;
    logic [STARVE_W-1:0] starve_q, starve_d;

    logic                fetch_wins;
    logic                if_gnt_c;
    logic                d_gnt_c;
    logic                mem_en_c;
    logic [BE_W-1:0]     mem_we_c;
    logic [ADDR_W-1:0]   mem_addr_c;
    logic [DATA_W-1:0]   mem_wdata_c;

    // Byte offset and bits above the memory size alias onto the word index.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.if_addr[31:ADDR_W+2], bus.if_addr[1:0],
                                bus.d_addr[31:ADDR_W+2],  bus.d_addr[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q  <= OWN_NONE;
            starve_q <= '0;
        end else begin
            owner_q  <= owner_d;
            starve_q <= starve_d;
        end
    end

    // Grant selection, memory drive, starvation and response-owner next state.
    always_comb begin
        fetch_wins  = 1'b0;
        if_gnt_c    = 1'b0;
        d_gnt_c     = 1'b0;
        mem_en_c    = 1'b0;
        mem_we_c    = '0;
        mem_addr_c  = '0;
        mem_wdata_c = '0;
        starve_d    = starve_q;
        owner_d     = OWN_NONE;

        fetch_wins = bus.if_req && (starve_q == STARVE_LIM);

        if (rst_n) begin
            if (bus.d_req && !fetch_wins) begin
                d_gnt_c = 1'b1;
            end else if (bus.if_req) begin
                if_gnt_c = 1'b1;
            end
        end

        if (if_gnt_c) begin
            mem_en_c   = 1'b1;
            mem_addr_c = bus.if_addr[ADDR_W+1:2];
            owner_d    = OWN_IF;
        end else if (d_gnt_c) begin
            mem_en_c    = 1'b1;
            mem_addr_c  = bus.d_addr[ADDR_W+1:2];
            mem_wdata_c = bus.d_wdata;
            if (bus.d_we) begin
                mem_we_c = bus.d_be;
            end else begin
                owner_d = OWN_D;
            end
        end

        if (!bus.if_req || if_gnt_c) begin
            starve_d = '0;
        end else if (d_gnt_c && (starve_q < STARVE_LIM)) begin
            starve_d = starve_q + STARVE_W'(1);
        end
    end

    assign bus.if_gnt    = if_gnt_c;
    assign bus.d_gnt     = d_gnt_c;
    assign bus.mem_en    = mem_en_c;
    assign bus.mem_we    = mem_we_c;
    assign bus.mem_addr  = mem_addr_c;
    assign bus.mem_wdata = mem_wdata_c;

    // Read data is shared; only the owner's rvalid qualifies it.
    assign bus.if_rvalid = (owner_q == OWN_IF);
    assign bus.d_rvalid  = (owner_q == OWN_D);
    assign bus.if_rdata  = bus.mem_rdata;
    assign bus.d_rdata   = bus.mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed table-driven bench for mem_port_arbiter with a behavioural sync-read memory.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 12;
    localparam logic [31:0] D_RD = 32'hFFFF_5678;
    localparam logic [31:0] F_RD = 32'hA5A5_A5A5;

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic        dw;
        logic [3:0]  dbe;
        logic [31:0] da;
        logic [31:0] dwd;
        logic [1:0]  g;   // 0 none, 1 fetch, 2 data
        logic [3:0]  we;
        logic [11:0] ma;
        logic [1:0]  rv;  // 0 none, 1 fetch, 2 data
        logic [31:0] rd;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_bad;
    vec_t tbl[$];
    logic [31:0] mem [0:(1<<AW)-1];

    mem_port_arbiter_if #(.ADDR_W(AW)) bus ();

    mem_port_arbiter #(.ADDR_W(AW), .STARVE_MAX(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_en) begin
            for (int b = 0; b < 4; b++)
                if (bus.mem_we[b]) mem[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    function automatic vec_t f(logic ir, logic [31:0] ia, logic dr, logic dw, logic [3:0] dbe,
                               logic [31:0] da, logic [31:0] dwd, logic [1:0] g, logic [3:0] we,
                               logic [11:0] ma, logic [1:0] rv, logic [31:0] rd);
        vec_t v;
        v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.dbe = dbe; v.da = da; v.dwd = dwd;
        v.g = g; v.we = we; v.ma = ma; v.rv = rv; v.rd = rd;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.if_req  = v.ir;
        bus.if_addr = v.ia;
        bus.d_req   = v.dr;
        bus.d_we    = v.dw;
        bus.d_be    = v.dbe;
        bus.d_addr  = v.da;
        bus.d_wdata = v.dwd;
    endtask

    task automatic check(input vec_t v, input string nm);
        logic [84:0] act;
        logic [84:0] exp;
        logic [31:0] rd_act;
        rd_act = (bus.if_rvalid | bus.d_rvalid) ? (bus.if_rvalid ? bus.if_rdata : bus.d_rdata) : 32'h0;
        act = {bus.if_gnt, bus.d_gnt, bus.mem_en, bus.mem_we,
               bus.mem_en ? bus.mem_addr : 12'h0,
               (bus.mem_we != 4'h0) ? bus.mem_wdata : 32'h0,
               bus.if_rvalid, bus.d_rvalid, rd_act};
        exp = {v.g == 2'd1, v.g == 2'd2, v.g != 2'd0, v.we,
               (v.g != 2'd0) ? v.ma : 12'h0,
               (v.we != 4'h0) ? v.dwd : 32'h0,
               v.rv == 2'd1, v.rv == 2'd2,
               (v.rv != 2'd0) ? v.rd : 32'h0};
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string nm);
        @(negedge clk);
        drive(v);
        #1;
        check(v, nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t both;
        vec_t idle;
        vec_t zero;
        n_vec = 0;
        n_bad = 0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
        mem[0] = F_RD;
        mem[1] = 32'h1111_1111;
        mem[4] = 32'hDEAD_BEEF;
        mem[8] = 32'hFFFF_FFFF;
        bus.mem_rdata = 32'h0;

        idle = f(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 2'd0, 4'h0, 12'h0, 2'd0, 32'h0);
        zero = idle;

        // Reset held with both requesters active, then first simultaneous requests.
        rst_n = 1'b1;
        drive(f(1, 32'h0, 1, 0, 4'hF, 32'h10, 32'h0, 2'd0, 4'h0, 12'h0, 2'd0, 32'h0));
        #1 rst_n = 1'b0;
        @(negedge clk); #1; check(zero, "rst_hold0");
        @(negedge clk); #1; check(zero, "rst_hold1");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check(f(1, 32'h0, 1, 0, 4'hF, 32'h10, 32'h0, 2'd2, 4'h0, 12'd4, 2'd0, 32'h0), "first_both");
        apply(f(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 2'd0, 4'h0, 12'h0, 2'd2, 32'hDEAD_BEEF), "first_resp");

        // Single-requester functions, write merge, aliasing.
        tbl.push_back(idle);
        tbl.push_back(f(1, 32'h10, 0, 0, 4'h0, 32'h0, 32'h0, 2'd1, 4'h0, 12'd4, 2'd0, 32'h0));
        tbl.push_back(f(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 2'd0, 4'h0, 12'h0, 2'd1, 32'hDEAD_BEEF));
        tbl.push_back(f(0, 32'h0, 1, 1, 4'b0011, 32'h20, 32'h1234_5678, 2'd2, 4'b0011, 12'd8, 2'd0, 32'h0));
        tbl.push_back(f(0, 32'h0, 1, 0, 4'hF, 32'h20, 32'h0, 2'd2, 4'h0, 12'd8, 2'd0, 32'h0));
        tbl.push_back(f(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 2'd0, 4'h0, 12'h0, 2'd2, D_RD));
        tbl.push_back(f(1, 32'h4004, 0, 0, 4'h0, 32'h0, 32'h0, 2'd1, 4'h0, 12'd1, 2'd0, 32'h0));
        tbl.push_back(f(1, 32'h3, 0, 0, 4'h0, 32'h0, 32'h0, 2'd1, 4'h0, 12'd0, 2'd1, 32'h1111_1111));
        tbl.push_back(f(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 2'd0, 4'h0, 12'h0, 2'd1, F_RD));

        // Continuous contention: D,D,D,D,IF repeating, responses one cycle later.
        for (int k = 0; k < 10; k++) begin
            logic [1:0] g;
            logic [1:0] rv;
            g  = ((k % 5) == 4) ? 2'd1 : 2'd2;
            rv = (k == 0) ? 2'd0 : ((((k - 1) % 5) == 4) ? 2'd1 : 2'd2);
            tbl.push_back(f(1, 32'h0, 1, 0, 4'hF, 32'h20, 32'h0, g, 4'h0,
                            (g == 2'd1) ? 12'd0 : 12'd8, rv, (rv == 2'd1) ? F_RD : D_RD));
        end
        tbl.push_back(f(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 2'd0, 4'h0, 12'h0, 2'd1, F_RD));

        // Fetch withdraws after three data wins; the counter restarts from zero.
        for (int k = 0; k < 3; k++)
            tbl.push_back(f(1, 32'h0, 1, 0, 4'hF, 32'h20, 32'h0, 2'd2, 4'h0, 12'd8,
                            (k == 0) ? 2'd0 : 2'd2, D_RD));
        tbl.push_back(f(0, 32'h0, 1, 0, 4'hF, 32'h20, 32'h0, 2'd2, 4'h0, 12'd8, 2'd2, D_RD));
        for (int k = 0; k < 4; k++)
            tbl.push_back(f(1, 32'h0, 1, 0, 4'hF, 32'h20, 32'h0, 2'd2, 4'h0, 12'd8, 2'd2, D_RD));
        tbl.push_back(f(1, 32'h0, 1, 0, 4'hF, 32'h20, 32'h0, 2'd1, 4'h0, 12'd0, 2'd2, D_RD));
        tbl.push_back(f(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 2'd0, 4'h0, 12'h0, 2'd1, F_RD));

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // Reset between a read grant and its response.
        both = f(1, 32'h0, 1, 0, 4'hF, 32'h20, 32'h0, 2'd2, 4'h0, 12'd8, 2'd0, 32'h0);
        apply(both, "pre_rst0");
        both.rv = 2'd2; both.rd = D_RD;
        apply(both, "pre_rst1");
        apply(both, "rst_grant");
        #2 rst_n = 1'b0;
        #1 check(zero, "rst_mid_gnt");
        @(negedge clk); #1; check(zero, "rst_mid_rv");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        both.rv = 2'd0;
        check(both, "rst_rel_first");
        both.rv = 2'd2;
        for (int k = 0; k < 3; k++) apply(both, $sformatf("rst_rel_d%0d", k));
        apply(f(1, 32'h0, 1, 0, 4'hF, 32'h20, 32'h0, 2'd1, 4'h0, 12'd0, 2'd2, D_RD), "rst_rel_if");
        apply(f(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 2'd0, 4'h0, 12'h0, 2'd1, F_RD), "rst_rel_resp");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
